wb_slot_arbiter: RTL and testbench
==================================

# wb_slot_arbiter

Shares the integer/FP result buses among issue queues whose ops have fixed, differing execution latencies. Each cycle it grants issue requests only if a result bus is free in the cycle the op will write back, reserving that slot. It replaces per-queue writeback reservation logic and sits between the issue queues and the execution units. It also tells the writeback mux which requester owns each bus in the current cycle.

## Interface
Parameters:
- NUM_REQ, 4, number of requesting issue queues
- NUM_WB, 2, number of shared result buses
- MAX_LAT, 8, largest supported execution latency in cycles; LW = $clog2(MAX_LAT+1)

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- IN_reqValid  in  [NUM_REQ]  requester wants to issue an op this cycle
- IN_reqLat  in  [NUM_REQ] x LW  latency of that op, legal range 1..MAX_LAT
- IN_busBlock  in  [NUM_WB]  bus is taken next cycle by an unscheduled source (load forward)
- OUT_grant  out  [NUM_REQ]  combinational; requester may issue this cycle
- OUT_grantBus  out  [NUM_REQ] x $clog2(NUM_WB)  bus assigned to the granted op
- OUT_wbValid  out  [NUM_WB]  registered; a scheduled op writes this bus in this cycle
- OUT_wbOwner  out  [NUM_WB] x $clog2(NUM_REQ)  registered; requester owning that bus in this cycle

## Operation
- State:
  - `resv[b][k]`: bus b is occupied k+1 cycles from now.
  - `owner[b][k]`: requester id for that slot.
  - `prio`: round-robin pointer, $clog2(NUM_REQ) bits.
- Request check: a request with latency L, L in 1..MAX_LAT, checks `resv[b][L-1]`.
  - For L==1 the bus must also have IN_busBlock[b]==0.
  - Requests with L==0 or L>MAX_LAT are never granted and cause no state change.
- Priority order is prio, prio+1, ..., modulo NUM_REQ.
- Bus selection: each request in priority order takes the lowest-index bus b that is free at L-1 and not already taken this cycle by a higher-priority grant with the same L.
  - If no such bus exists, the request gets grant=0.
  - Requests with different latencies never conflict.
- Sequential update each cycle:
  - Shift: `resv[b] <= resv[b] >> 1`; owner shifts alongside.
  - For each grant, set bit L-2 of the shifted result with owner = requester id.
  - A grant with L==1 sets no table bit; the bus goes directly to OUT_wbValid/OUT_wbOwner the next cycle.
  - Otherwise OUT_wbValid[b] <= `resv[b][0]` and OUT_wbOwner[b] <= `owner[b][0]`.
- Pointer: if any grant occurs, prio <= (first granted requester in priority order + 1) mod NUM_REQ; otherwise it is unchanged.
- No flush input. Ops squashed after issue still hold their slot; the slot is wasted and the writeback side discards the result by tag.
- Reset:
  - resv, owner, prio, OUT_wbValid and OUT_wbOwner are cleared to 0.
  - OUT_grant is forced to 0 while rst is high.
  - OUT_grantBus is 0 whenever its grant is 0.
  - A reset mid-operation drops all reservations.

## Timing
- A grant in cycle t with latency L yields OUT_wbValid[b]=1 and OUT_wbOwner[b]=id in cycle t+L.
- Grant is combinational with the request: it depends on registered state plus the same-cycle inputs IN_reqValid, IN_reqLat and IN_busBlock.
- Back-to-back grants are allowed every cycle.
- Full table, where all buses are reserved at L-1: every latency-L request is denied that cycle and retried by the requester.
- Simultaneous grants to the same bus at different L are always legal.

## Configuration
- WB_ARB_RR_EN:
  - Defined: round-robin priority via prio, as above.
  - Undefined: fixed priority with requester 0 highest; prio is not implemented and is treated as constant 0.

## Structure
- Shared package: the `WbSlot` struct (valid bit plus owner id) and the constant MAX_LAT default.
- One sub-module, `wb_arb_prio`: rotates the request vector by prio, returns the granted order, and computes the next pointer.
- Top level holds the reservation table, the bus-select loop and the output registers.

## Test plan
- Single request: req0 L=3 at cycle 5 -> grant0=1, bus 0 at cycle 5; OUT_wbValid[0]=1 and owner 0 at cycle 8.
- Contention: NUM_WB=2; req0, req1 and req2 all L=2 in one cycle, prio=0 -> req0 gets bus 0, req1 gets bus 1, req2 is denied; prio becomes 1.
- Cross-cycle conflict: req0 L=4 at t, then req1 L=3 at t+1 on a one-bus config -> req1 denied (same writeback cycle); req1 L=2 at t+1 granted.
- Block: IN_busBlock=2'b11 with req0 L=1 -> denied; req0 L=2 in the same cycle -> granted.
- Fairness (WB_ARB_RR_EN defined): req0 and req1 both L=1 continuously on one bus -> grants alternate 0,1,0,1; with the macro undefined -> req0 is always granted.
- Reset mid-operation: with reservations pending at L=5, assert rst for 1 cycle -> OUT_wbValid is 0 for all later cycles until new grants; illegal L=0 or L=9 requests are never granted.

Source files
------------

// File: rtl/wb_slot_arbiter_pkg.sv
// wb_slot_arbiter_pkg: shared types and defaults for the writeback slot arbiter.
package wb_slot_arbiter_pkg;
    localparam int MAX_LAT_DEF = 8;
    localparam int NUM_REQ_DEF = 4;
    localparam int ID_W        = $clog2(NUM_REQ_DEF);
    typedef struct packed {
        logic            valid;
        logic [ID_W-1:0] owner;
    } WbSlot;
endpackage

// File: rtl/wb_slot_arbiter_if.sv
// wb_slot_arbiter_if: issue-request / writeback-ownership bundle between issue queues and the arbiter.
interface wb_slot_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int NUM_WB  = 2,
    parameter int MAX_LAT = 8
);
    localparam int LW = $clog2(MAX_LAT + 1);
    localparam int BW = NUM_WB > 1 ? $clog2(NUM_WB) : 1;
    localparam int IW = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1;
    logic [NUM_REQ-1:0]         IN_reqValid;
    logic [NUM_REQ-1:0][LW-1:0] IN_reqLat;
    logic [NUM_WB-1:0]          IN_busBlock;
    logic [NUM_REQ-1:0]         OUT_grant;
    logic [NUM_REQ-1:0][BW-1:0] OUT_grantBus;
    logic [NUM_WB-1:0]          OUT_wbValid;
    logic [NUM_WB-1:0][IW-1:0]  OUT_wbOwner;
    modport master (
        output IN_reqValid, IN_reqLat, IN_busBlock,
        input  OUT_grant, OUT_grantBus, OUT_wbValid, OUT_wbOwner
    );
    modport slave (
        input  IN_reqValid, IN_reqLat, IN_busBlock,
        output OUT_grant, OUT_grantBus, OUT_wbValid, OUT_wbOwner
    );
endinterface

// File: rtl/wb_slot_arbiter_prio.sv
// wb_arb_prio: priority order from the pointer and next pointer after grants.
// Pointer update ports exist only with WB_ARB_RR_EN defined.
module wb_arb_prio #(
    parameter int NUM_REQ = 4,
    parameter int IW      = 2
) (
    input  logic [IW-1:0]              i_prio,
`ifdef WB_ARB_RR_EN
    input  logic [NUM_REQ-1:0]         i_grant,
    output logic [IW-1:0]              o_next_prio,
`endif
    output logic [NUM_REQ-1:0][IW-1:0] o_order
);
    always_comb begin
        for (int k = 0; k < NUM_REQ; k++)
            o_order[k] = IW'((int'(i_prio) + k) % NUM_REQ);
    end
`ifdef WB_ARB_RR_EN
    // Walk from lowest priority upward so the first granted requester wins.
    always_comb begin
        o_next_prio = i_prio;
        for (int k = NUM_REQ - 1; k >= 0; k--)
            for (int j = 0; j < NUM_REQ; j++)
                if (o_order[k] == IW'(j) && i_grant[j])
                    o_next_prio = IW'((j + 1) % NUM_REQ);
    end
`endif
endmodule

// File: rtl/wb_slot_arbiter.sv
// wb_slot_arbiter: grants issue only when a result bus is free at the op's writeback cycle.
// WB_ARB_RR_EN selects round-robin priority; otherwise requester 0 is always highest.
module wb_slot_arbiter
    import wb_slot_arbiter_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF,
    parameter int NUM_WB  = 2,
    parameter int MAX_LAT = MAX_LAT_DEF
) (
    input logic              clk,
    input logic              rst,
    wb_slot_arbiter_if.slave bus
);
    localparam int BW = NUM_WB > 1 ? $clog2(NUM_WB) : 1;
    localparam int IW = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1;
    WbSlot [NUM_WB-1:0][MAX_LAT-1:0] r_tab;
    WbSlot [NUM_WB-1:0]              r_wb;
    WbSlot [NUM_WB-1:0][MAX_LAT-1:0] w_tab_nxt;
    WbSlot [NUM_WB-1:0]              w_wb_nxt;
    logic  [NUM_WB-1:0][MAX_LAT-1:0] w_taken;
    logic  [NUM_REQ-1:0]             w_grant;
    logic  [NUM_REQ-1:0][BW-1:0]     w_bus;
    logic  [NUM_REQ-1:0][IW-1:0]     w_order;
    logic  [IW-1:0]                  w_prio;
`ifdef WB_ARB_RR_EN
    logic  [IW-1:0]                  r_prio;
    logic  [IW-1:0]                  w_next_prio;
    assign w_prio = r_prio;
    always_ff @(posedge clk)
        r_prio <= rst ? '0 : w_next_prio;
    wb_arb_prio #(.NUM_REQ(NUM_REQ), .IW(IW)) u_prio (
        .i_prio      (w_prio),
        .i_grant     (w_grant),
        .o_next_prio (w_next_prio),
        .o_order     (w_order)
    );
`else
    assign w_prio = '0;
    wb_arb_prio #(.NUM_REQ(NUM_REQ), .IW(IW)) u_prio (
        .i_prio  (w_prio),
        .o_order (w_order)
    );
`endif
    // Same-latency grants in one cycle compete for the same slot, tracked in w_taken.
    always_comb begin
        w_taken = '0;
        w_grant = '0;
        w_bus   = '0;
        for (int k = 0; k < NUM_REQ; k++)
            for (int j = 0; j < NUM_REQ; j++)
                if (w_order[k] == IW'(j) && bus.IN_reqValid[j] && !rst) begin
                    for (int b = 0; b < NUM_WB; b++)
                        for (int s = 0; s < MAX_LAT; s++)
                            if (!w_grant[j] && int'(bus.IN_reqLat[j]) == s + 1 && !r_tab[b][s].valid &&
                                !w_taken[b][s] && !(s == 0 && bus.IN_busBlock[b])) begin
                                w_grant[j]    = 1'b1;
                                w_bus[j]      = BW'(b);
                                w_taken[b][s] = 1'b1;
                            end
                end
    end
    always_comb begin
        w_tab_nxt = '0;
        w_wb_nxt  = '0;
        for (int b = 0; b < NUM_WB; b++) begin
            w_wb_nxt[b] = r_tab[b][0];
            for (int s = 0; s < MAX_LAT - 1; s++)
                w_tab_nxt[b][s] = r_tab[b][s+1];
        end
        for (int j = 0; j < NUM_REQ; j++)
            for (int b = 0; b < NUM_WB; b++)
                for (int s = 0; s < MAX_LAT; s++)
                    if (w_grant[j] && w_bus[j] == BW'(b) && int'(bus.IN_reqLat[j]) == s + 1) begin
                        if (s == 0)
                            w_wb_nxt[b] = '{valid: 1'b1, owner: ID_W'(j)};
                        else
                            w_tab_nxt[b][s-1] = '{valid: 1'b1, owner: ID_W'(j)};
                    end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tab <= '0;
            r_wb  <= '0;
        end else begin
            r_tab <= w_tab_nxt;
            r_wb  <= w_wb_nxt;
        end
    end
    assign bus.OUT_grant    = w_grant;
    assign bus.OUT_grantBus = w_bus;
    always_comb begin
        for (int b = 0; b < NUM_WB; b++) begin
            bus.OUT_wbValid[b] = r_wb[b].valid;
            bus.OUT_wbOwner[b] = r_wb[b].owner;
        end
    end
endmodule

// File: tb/tb_wb_slot_arbiter.sv
// tb_wb_slot_arbiter: scoreboard bench for a two-bus and a one-bus arbiter instance.
module tb_wb_slot_arbiter;
    typedef struct {
        int due;
        int d;
        int b;
        int id;
    } exp_t;
    exp_t sb[$];
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_vec = 0;
    int   n_bad = 0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    wb_slot_arbiter_if #(.NUM_REQ(4), .NUM_WB(2), .MAX_LAT(8)) ifa ();
    wb_slot_arbiter_if #(.NUM_REQ(4), .NUM_WB(1), .MAX_LAT(8)) ifb ();
    wb_slot_arbiter #(.NUM_REQ(4), .NUM_WB(2), .MAX_LAT(8)) dut_a (.clk(clk), .rst(rst), .bus(ifa.slave));
    wb_slot_arbiter #(.NUM_REQ(4), .NUM_WB(1), .MAX_LAT(8)) dut_b (.clk(clk), .rst(rst), .bus(ifb.slave));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_wb();
        for (int d = 0; d < 2; d++)
            for (int b = 0; b < (d == 0 ? 2 : 1); b++) begin
                logic ev = 1'b0;
                int   eo = 0;
                logic gv;
                int   go;
                for (int i = sb.size() - 1; i >= 0; i--)
                    if (sb[i].due == cyc && sb[i].d == d && sb[i].b == b) begin
                        ev = 1'b1;
                        eo = sb[i].id;
                        sb.delete(i);
                    end
                gv = d == 0 ? ifa.OUT_wbValid[b] : ifb.OUT_wbValid[0];
                go = d == 0 ? int'(ifa.OUT_wbOwner[b]) : int'(ifb.OUT_wbOwner[0]);
                chk($sformatf("wbValid d%0d b%0d c%0d", d, b, cyc), 32'(gv), 32'(ev));
                if (ev) chk($sformatf("wbOwner d%0d b%0d c%0d", d, b, cyc), go, eo);
            end
    endtask

    task automatic clear_inputs();
        ifa.IN_reqValid = '0;
        ifa.IN_reqLat   = '0;
        ifa.IN_busBlock = '0;
        ifb.IN_reqValid = '0;
        ifb.IN_reqLat   = '0;
        ifb.IN_busBlock = '0;
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
            clear_inputs();
            check_wb();
        end
    endtask

    task automatic req(input int d, input logic [3:0] v, input int l0, input int l1, input int l2,
                       input int l3, input logic [1:0] blk, input logic [3:0] eg, input logic [3:0] eb);
        int lat[4];
        lat = '{l0, l1, l2, l3};
        if (d == 0) begin
            ifa.IN_reqValid = v;
            for (int i = 0; i < 4; i++) ifa.IN_reqLat[i] = 4'(lat[i]);
            ifa.IN_busBlock = blk;
        end else begin
            ifb.IN_reqValid = v;
            for (int i = 0; i < 4; i++) ifb.IN_reqLat[i] = 4'(lat[i]);
            ifb.IN_busBlock = blk[0];
        end
        #1;
        for (int i = 0; i < 4; i++) begin
            logic g  = d == 0 ? ifa.OUT_grant[i] : ifb.OUT_grant[i];
            logic gb = d == 0 ? ifa.OUT_grantBus[i] : ifb.OUT_grantBus[i];
            chk($sformatf("grant d%0d r%0d c%0d", d, i, cyc), 32'(g), 32'(eg[i]));
            chk($sformatf("grantBus d%0d r%0d c%0d", d, i, cyc), 32'(gb), 32'(eg[i] & eb[i]));
            if (eg[i] && !rst) sb.push_back('{due: cyc + lat[i], d: d, b: int'(eb[i]), id: i});
        end
    endtask

    // Outstanding slots that would land after the reset edge are dropped by the DUT.
    task automatic do_reset();
        rst = 1'b1;
        for (int i = sb.size() - 1; i >= 0; i--)
            if (sb[i].due > cyc) sb.delete(i);
        req(0, 4'b1111, 1, 2, 3, 4, 2'b00, 4'b0000, 4'b0000);
        req(1, 4'b1111, 1, 2, 3, 4, 2'b00, 4'b0000, 4'b0000);
        tick();
        rst = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        clear_inputs();
        tick(2);
        do_reset();
        tick();
        // Single request, latency 3
        req(0, 4'b0001, 3, 0, 0, 0, 2'b00, 4'b0001, 4'b0000);
        tick(4);
        // Contention on two buses, then priority observed through a second round
        do_reset();
        req(0, 4'b0111, 2, 2, 2, 0, 2'b00, 4'b0011, 4'b0010);
        tick();
`ifdef WB_ARB_RR_EN
        req(0, 4'b0111, 3, 3, 3, 0, 2'b00, 4'b0110, 4'b0100);
`else
        req(0, 4'b0111, 3, 3, 3, 0, 2'b00, 4'b0011, 4'b0010);
`endif
        tick(4);
        // Cross-cycle conflict on the single-bus instance
        do_reset();
        req(1, 4'b0001, 4, 0, 0, 0, 2'b00, 4'b0001, 4'b0000);
        tick();
        req(1, 4'b0110, 0, 3, 2, 0, 2'b00, 4'b0100, 4'b0000);
        tick();
        req(1, 4'b0010, 0, 3, 0, 0, 2'b00, 4'b0010, 4'b0000);
        tick(5);
        // Bus blocking, same-bus different-latency grants, illegal and maximum latencies
        do_reset();
        req(0, 4'b0011, 1, 2, 0, 0, 2'b11, 4'b0010, 4'b0000);
        tick();
        req(0, 4'b0001, 1, 0, 0, 0, 2'b01, 4'b0001, 4'b0001);
        tick();
        req(0, 4'b0011, 1, 2, 0, 0, 2'b00, 4'b0011, 4'b0000);
        tick();
        req(0, 4'b0011, 0, 9, 0, 0, 2'b00, 4'b0000, 4'b0000);
        tick();
        req(0, 4'b0001, 8, 0, 0, 0, 2'b00, 4'b0001, 4'b0000);
        tick(9);
        // Fairness between two L=1 requesters on one bus
        do_reset();
        for (int c = 0; c < 4; c++) begin
`ifdef WB_ARB_RR_EN
            req(1, 4'b0011, 1, 1, 0, 0, 2'b00, (c % 2 == 1) ? 4'b0010 : 4'b0001, 4'b0000);
`else
            req(1, 4'b0011, 1, 1, 0, 0, 2'b00, 4'b0001, 4'b0000);
`endif
            tick();
        end
        tick();
        // Reset while L=5 reservations are pending
        req(0, 4'b0011, 5, 5, 0, 0, 2'b00, 4'b0011, 4'b0010);
        tick(2);
        do_reset();
        tick(7);
        chk("scoreboard drained", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
